// File: rtl/tfhe_pbs_job_sequencer.sv
// Sequences one TFHE programmable-bootstrap job: DMA load, PBS core run, DMA store.
// All status/command outputs come from flops; a watchdog aborts any stalled cmd/wait step.
module tfhe_pbs_job_sequencer #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          BEAT_BYTES   = 64,
    parameter int          RESULT_LEN   = 2048,
    parameter logic [1:0]  HBM_SEL_TFHE = 2'b01,
    parameter int          WDT_WIDTH    = 24
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  start_pbs,
    input  logic                  tfhe_reset_n,
    input  logic [1:0]            hbm_select,
    input  logic [DATA_WIDTH-1:0] host_wr_addr,
    input  logic [DATA_WIDTH-1:0] host_wr_len,
    output logic                  dma_in_cmd_valid,
    input  logic                  dma_in_cmd_ready,
    output logic [DATA_WIDTH-1:0] dma_in_cmd_addr,
    output logic [DATA_WIDTH-1:0] dma_in_cmd_len,
    input  logic                  dma_in_done,
    output logic                  pbs_core_start,
    input  logic                  pbs_core_done,
    output logic                  dma_out_cmd_valid,
    input  logic                  dma_out_cmd_ready,
    output logic [DATA_WIDTH-1:0] dma_out_cmd_addr,
    output logic [DATA_WIDTH-1:0] dma_out_cmd_len,
    input  logic                  dma_out_done,
    output logic                  pbs_busy,
    output logic                  pbs_done,
    output logic                  pbs_error,
    output logic [DATA_WIDTH-1:0] host_rd_addr,
    output logic [DATA_WIDTH-1:0] host_rd_len
);

    localparam int                   DW       = DATA_WIDTH;
    localparam logic [DW-1:0]        BEAT     = DW'(BEAT_BYTES);
    localparam logic [DW-1:0]        RES_LEN  = DW'(RESULT_LEN);
    localparam logic [WDT_WIDTH-1:0] WDT_LAST = {WDT_WIDTH{1'b1}} - WDT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_CMD, S_LOAD_WAIT, S_PBS_RUN,
        S_STORE_CMD, S_STORE_WAIT, S_DONE, S_ERROR
    } state_t;

    state_t                 state, state_n;
    logic                   en_q;
    logic [DW-1:0]          addr_q, len_q, sum_q;
    logic [WDT_WIDTH-1:0]   wdt;
    logic                   busy_q, done_q, err_q, in_vld_q, out_vld_q, start_q;
    logic [DW-1:0]          rd_addr_q, rd_len_q;

    logic                   launch, launch_ok, wdt_active, wdt_expire;
    logic [DW+1:0]          span;

    assign launch     = (state == S_IDLE) && tfhe_reset_n && !en_q && start_pbs;
    // Two extra bits catch any carry of the full input+result window.
    assign span       = {2'b00, host_wr_addr} + {2'b00, host_wr_len} + {2'b00, RES_LEN};
    assign launch_ok  = (hbm_select == HBM_SEL_TFHE) && (host_wr_len != '0) &&
                        ((host_wr_len % BEAT) == '0) && (span[DW+1:DW] == 2'b00);
    assign wdt_active = (state == S_LOAD_CMD)  || (state == S_LOAD_WAIT) ||
                        (state == S_STORE_CMD) || (state == S_STORE_WAIT);
    assign wdt_expire = wdt_active && (wdt == WDT_LAST);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= S_IDLE;
        else        state <= state_n;
    end

    // Completions are tested before the watchdog so they win a same-cycle tie.
    always_comb begin
        state_n = state;
        if (!tfhe_reset_n) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:       if (launch) state_n = launch_ok ? S_LOAD_CMD : S_ERROR;
                S_LOAD_CMD:   if (dma_in_cmd_ready)  state_n = S_LOAD_WAIT;
                              else if (wdt_expire)   state_n = S_ERROR;
                S_LOAD_WAIT:  if (dma_in_done)       state_n = S_PBS_RUN;
                              else if (wdt_expire)   state_n = S_ERROR;
                S_PBS_RUN:    if (pbs_core_done)     state_n = S_STORE_CMD;
                S_STORE_CMD:  if (dma_out_cmd_ready) state_n = S_STORE_WAIT;
                              else if (wdt_expire)   state_n = S_ERROR;
                S_STORE_WAIT: if (dma_out_done)      state_n = S_DONE;
                              else if (wdt_expire)   state_n = S_ERROR;
                default:      state_n = state;
            endcase
        end
    end

    // en_q comes out of reset high so a job needs a genuine enable rise after reset.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            en_q      <= 1'b1;
            addr_q    <= '0;
            len_q     <= '0;
            sum_q     <= '0;
            wdt       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            in_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            start_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_len_q  <= '0;
        end else begin
            en_q <= tfhe_reset_n;
            if (launch) begin
                addr_q <= host_wr_addr;
                len_q  <= host_wr_len;
                sum_q  <= host_wr_addr + host_wr_len;
            end
            if (state_n != state) wdt <= '0;
            else if (wdt_active)  wdt <= wdt + WDT_WIDTH'(1);
            busy_q    <= state_n inside {S_LOAD_CMD, S_LOAD_WAIT, S_PBS_RUN, S_STORE_CMD, S_STORE_WAIT};
            done_q    <= state_n inside {S_DONE, S_ERROR};
            err_q     <= (state_n == S_ERROR);
            in_vld_q  <= (state_n == S_LOAD_CMD);
            out_vld_q <= (state_n == S_STORE_CMD);
            start_q   <= (state_n == S_PBS_RUN) && (state != S_PBS_RUN);
            if (state == S_STORE_WAIT && state_n == S_DONE) begin
                rd_addr_q <= sum_q;
                rd_len_q  <= RES_LEN;
            end
        end
    end

    assign dma_in_cmd_valid  = in_vld_q;
    assign dma_in_cmd_addr   = in_vld_q  ? addr_q  : '0;
    assign dma_in_cmd_len    = in_vld_q  ? len_q   : '0;
    assign dma_out_cmd_valid = out_vld_q;
    assign dma_out_cmd_addr  = out_vld_q ? sum_q   : '0;
    assign dma_out_cmd_len   = out_vld_q ? RES_LEN : '0;
    assign pbs_core_start    = start_q;
    assign pbs_busy          = busy_q;
    assign pbs_done          = done_q;
    assign pbs_error         = err_q;
    assign host_rd_addr      = rd_addr_q;
    assign host_rd_len       = rd_len_q;

endmodule

// File: tb/tb_tfhe_pbs_job_sequencer.sv
// Directed bench for the PBS job sequencer: a phase-level job model checked every cycle,
// plus literal expectations for the nominal, error, abort, watchdog and reset scenarios.
module tb_tfhe_pbs_job_sequencer;

    logic        ACLK = 1'b0, ARESET = 1'b1;
    logic        start_pbs = 1'b0, tfhe_reset_n = 1'b0;
    logic [1:0]  hbm_select = 2'b00;
    logic [31:0] host_wr_addr = '0, host_wr_len = '0;
    logic        dma_in_cmd_valid, dma_in_cmd_ready = 1'b1;
    logic [31:0] dma_in_cmd_addr, dma_in_cmd_len;
    logic        dma_in_done = 1'b0, pbs_core_start, pbs_core_done = 1'b0;
    logic        dma_out_cmd_valid, dma_out_cmd_ready = 1'b1;
    logic [31:0] dma_out_cmd_addr, dma_out_cmd_len;
    logic        dma_out_done = 1'b0, pbs_busy, pbs_done, pbs_error;
    logic [31:0] host_rd_addr, host_rd_len;

    always #5 ACLK = ~ACLK;

    tfhe_pbs_job_sequencer #(.WDT_WIDTH(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start_pbs(start_pbs), .tfhe_reset_n(tfhe_reset_n),
        .hbm_select(hbm_select), .host_wr_addr(host_wr_addr), .host_wr_len(host_wr_len),
        .dma_in_cmd_valid(dma_in_cmd_valid), .dma_in_cmd_ready(dma_in_cmd_ready),
        .dma_in_cmd_addr(dma_in_cmd_addr), .dma_in_cmd_len(dma_in_cmd_len),
        .dma_in_done(dma_in_done), .pbs_core_start(pbs_core_start), .pbs_core_done(pbs_core_done),
        .dma_out_cmd_valid(dma_out_cmd_valid), .dma_out_cmd_ready(dma_out_cmd_ready),
        .dma_out_cmd_addr(dma_out_cmd_addr), .dma_out_cmd_len(dma_out_cmd_len),
        .dma_out_done(dma_out_done), .pbs_busy(pbs_busy), .pbs_done(pbs_done),
        .pbs_error(pbs_error), .host_rd_addr(host_rd_addr), .host_rd_len(host_rd_len)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job model: phases 0 idle,1 load cmd,2 load wait,3 core run,4 store cmd,5 store wait,6 done,7 error
    int          m_ph = 0, m_entry = 0, cyc = 0;
    bit          m_prev = 1'b1, m_pulse = 1'b0;
    logic [31:0] m_a = '0, m_l = '0, m_rda = '0, m_rdl = '0;

    initial forever begin : model
        int  np;
        bit  timeout;
        longint span;
        @(posedge ACLK); #1;
        cyc++;
        if (ARESET) begin
            m_ph = 0; m_a = '0; m_l = '0; m_rda = '0; m_rdl = '0;
            m_prev = 1'b1; m_pulse = 1'b0; m_entry = cyc;
        end else begin
            np = m_ph;
            m_pulse = 1'b0;
            timeout = (m_ph == 1 || m_ph == 2 || m_ph == 4 || m_ph == 5) && (cyc - m_entry == 15);
            if (!tfhe_reset_n) np = 0;
            else case (m_ph)
                0: if (!m_prev && start_pbs) begin
                       m_a = host_wr_addr; m_l = host_wr_len;
                       span = longint'(host_wr_addr) + longint'(host_wr_len) + 2048;
                       np = (hbm_select == 2'b01 && host_wr_len != 0 && host_wr_len % 64 == 0 &&
                             span < 64'h1_0000_0000) ? 1 : 7;
                   end
                1: if (dma_in_cmd_ready) np = 2; else if (timeout) np = 7;
                2: if (dma_in_done) begin np = 3; m_pulse = 1'b1; end else if (timeout) np = 7;
                3: if (pbs_core_done) np = 4;
                4: if (dma_out_cmd_ready) np = 5; else if (timeout) np = 7;
                5: if (dma_out_done) begin np = 6; m_rda = m_a + m_l; m_rdl = 32'd2048; end
                   else if (timeout) np = 7;
                default: np = m_ph;
            endcase
            if (np != m_ph) m_entry = cyc;
            m_ph = np;
            m_prev = tfhe_reset_n;
        end
    end

    initial forever begin : compare
        @(posedge ACLK); #3;
        chk("status", 128'({pbs_busy, pbs_done, pbs_error, dma_in_cmd_valid, dma_out_cmd_valid, pbs_core_start}),
            128'({(m_ph >= 1 && m_ph <= 5), m_ph >= 6, m_ph == 7, m_ph == 1, m_ph == 4, m_pulse}));
        chk("load_cmd", 128'({dma_in_cmd_addr, dma_in_cmd_len}), 128'(m_ph == 1 ? {m_a, m_l} : 64'd0));
        chk("store_cmd", 128'({dma_out_cmd_addr, dma_out_cmd_len}),
            128'(m_ph == 4 ? {m_a + m_l, 32'd2048} : 64'd0));
        chk("host_rd", 128'({host_rd_addr, host_rd_len}), 128'({m_rda, m_rdl}));
    end

    // Responders: completion pulses land 5 cycles after each accept / core start.
    int in_cd = 0, core_cd = 0, out_cd = 0, in_hs = 0, core_pulses = 0;
    bit out_en = 1'b1;
    logic [63:0] cap_in = '0, cap_out = '0;

    initial forever begin : responder
        @(negedge ACLK); #1;
        dma_in_done = 1'b0; pbs_core_done = 1'b0; dma_out_done = 1'b0;
        if (in_cd > 0)   begin in_cd--;   if (in_cd == 0)   dma_in_done = 1'b1;   end
        if (core_cd > 0) begin core_cd--; if (core_cd == 0) pbs_core_done = 1'b1; end
        if (out_cd > 0)  begin out_cd--;  if (out_cd == 0)  dma_out_done = 1'b1;  end
        if (dma_in_cmd_valid && dma_in_cmd_ready) begin
            in_cd = 5; in_hs++; cap_in = {dma_in_cmd_addr, dma_in_cmd_len};
        end
        if (pbs_core_start) begin core_cd = 5; core_pulses++; end
        if (dma_out_cmd_valid && dma_out_cmd_ready) begin
            cap_out = {dma_out_cmd_addr, dma_out_cmd_len};
            if (out_en) out_cd = 5;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    task automatic soft_reset();
        @(negedge ACLK);
        tfhe_reset_n = 1'b0; start_pbs = 1'b0;
        tick(2);
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] l, input logic [1:0] sel);
        @(negedge ACLK);
        host_wr_addr = a; host_wr_len = l; hbm_select = sel;
        start_pbs = 1'b1; tfhe_reset_n = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!pbs_done && k < 200) begin tick(1); k++; end
        chk({name, "_done"}, 128'(pbs_done), 128'(1));
    endtask

    task automatic wait_core_start(input string name);
        int k = 0;
        while (!pbs_core_start && k < 100) begin tick(1); k++; end
        chk({name, "_core_start"}, 128'(pbs_core_start), 128'(1));
    endtask

    typedef struct { logic [31:0] a; logic [31:0] l; logic [1:0] sel; bit err; } chk_vec_t;
    chk_vec_t vecs[6] = '{
        '{32'h0000_1000, 32'h30,  2'b01, 1'b1},   // length not a beat multiple
        '{32'h0000_1000, 32'h0,   2'b01, 1'b1},   // zero length
        '{32'h0000_1000, 32'h400, 2'b00, 1'b1},   // HBM owned elsewhere
        '{32'hFFFF_F800, 32'h40,  2'b01, 1'b1},   // window wraps
        '{32'hFFFF_F000, 32'h800, 2'b01, 1'b1},   // window ends exactly at 2**32
        '{32'hFFFF_F000, 32'h7C0, 2'b01, 1'b0}    // last beat fits
    };

    initial begin : stim
        int n;
        int k;
        tick(3);
        chk("reset_status", 128'({pbs_busy, pbs_done, pbs_error, dma_in_cmd_valid, dma_out_cmd_valid, pbs_core_start}), 128'(0));
        ARESET = 1'b0;
        tick(2);

        // Nominal job
        core_pulses = 0;
        launch(32'h1000, 32'h400, 2'b01);
        wait_done("nominal");
        chk("nominal_err", 128'(pbs_error), 128'(0));
        chk("nominal_rd_addr", 128'(host_rd_addr), 128'(32'h1400));
        chk("nominal_rd_len", 128'(host_rd_len), 128'(2048));
        chk("nominal_load_cmd", 128'(cap_in), 128'({32'h1000, 32'h400}));
        chk("nominal_store_cmd", 128'(cap_out), 128'({32'h1400, 32'd2048}));
        chk("nominal_core_pulses", 128'(core_pulses), 128'(1));
        tick(3);
        chk("done_sticky", 128'(pbs_done), 128'(1));

        soft_reset();
        chk("soft_reset_done", 128'({pbs_done, pbs_busy}), 128'(0));
        chk("soft_reset_keeps_rd", 128'(host_rd_addr), 128'(32'h1400));

        // Launch checks, each error visible one cycle after the launch edge
        foreach (vecs[i]) begin
            launch(vecs[i].a, vecs[i].l, vecs[i].sel);
            tick(1);
            chk("launch_check_err", 128'({pbs_error, pbs_done, pbs_busy}),
                128'(vecs[i].err ? 3'b110 : 3'b001));
            soft_reset();
        end

        // Retry with the right owner after a wrong-owner error
        launch(32'h2000, 32'h80, 2'b01);
        wait_done("retry");
        chk("retry_rd_addr", 128'(host_rd_addr), 128'(32'h2080));
        soft_reset();

        // Load command backpressure
        dma_in_cmd_ready = 1'b0; in_hs = 0;
        launch(32'h3000, 32'h100, 2'b01);
        tick(11);
        chk("bp_valid_held", 128'({dma_in_cmd_valid, dma_in_cmd_addr, dma_in_cmd_len}),
            128'({1'b1, 32'h3000, 32'h100}));
        dma_in_cmd_ready = 1'b1;
        wait_done("bp");
        chk("bp_handshakes", 128'(in_hs), 128'(1));
        chk("bp_rd_addr", 128'(host_rd_addr), 128'(32'h3100));
        soft_reset();

        // Abort during the core run; the late core done must be ignored
        core_pulses = 0;
        launch(32'h5000, 32'h80, 2'b01);
        wait_core_start("abort");
        tick(1);
        tfhe_reset_n = 1'b0;
        tick(1);
        chk("abort_busy", 128'(pbs_busy), 128'(0));
        tick(8);
        chk("abort_idle", 128'({pbs_busy, pbs_done, dma_out_cmd_valid}), 128'(0));
        chk("abort_rd_kept", 128'(host_rd_addr), 128'(32'h3100));

        // Watchdog in store wait
        out_en = 1'b0;
        launch(32'h4000, 32'h40, 2'b01);
        k = 0;
        while (!(dma_out_cmd_valid && dma_out_cmd_ready) && k < 100) begin tick(1); k++; end
        chk("wdt_store_cmd", 128'(dma_out_cmd_valid), 128'(1));
        tick(1);
        n = 0;
        while (pbs_busy && n < 40) begin n++; tick(1); end
        chk("wdt_cycles", 128'(n), 128'(15));
        chk("wdt_error", 128'({pbs_error, pbs_done}), 128'(2'b11));
        chk("wdt_rd_kept", 128'(host_rd_addr), 128'(32'h3100));
        out_en = 1'b1;
        soft_reset();

        // Asynchronous reset mid-job
        launch(32'h6000, 32'h40, 2'b01);
        wait_core_start("areset");
        tick(2);
        ARESET = 1'b1; start_pbs = 1'b0; tfhe_reset_n = 1'b0;
        #1;
        chk("areset_status", 128'({pbs_busy, pbs_done, pbs_error, dma_in_cmd_valid, dma_out_cmd_valid, pbs_core_start}), 128'(0));
        chk("areset_cmds", 128'({dma_in_cmd_addr, dma_in_cmd_len, dma_out_cmd_addr, dma_out_cmd_len}), 128'(0));
        chk("areset_rd", 128'({host_rd_addr, host_rd_len}), 128'(0));
        tick(3);
        ARESET = 1'b0;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
